// File: rtl/ft245_pkg.sv
// Shared constants for the FT245 synchronous-FIFO device emulation.
package ft245_pkg;
    localparam int FT245_DATA_W         = 8;
    localparam int FT245_DEPTH_LOG2     = 4;
    localparam int FT245_STARTUP_CYCLES = 8;
endpackage

// File: rtl/ft245_dev_fifo.sv
// Byte FIFO with push/pop, occupancy, next-occupancy and a combinational head
// (head reads zero while empty).
module ft245_dev_fifo
    import ft245_pkg::*;
#(
    parameter int DEPTH_LOG2 = FT245_DEPTH_LOG2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [FT245_DATA_W-1:0] din,
    output logic [FT245_DATA_W-1:0] head,
    output logic [DEPTH_LOG2:0]     level,
    output logic [DEPTH_LOG2:0]     level_next
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [FT245_DATA_W-1:0] mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;

    always_comb begin
        level_next = level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            level <= level_next;
        end
    end

    // Storage is not reset; the empty gate on head hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head = (level != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/ft245sff_dev.sv
// FT2232H-side emulation of the FT245 synchronous FIFO bus with host streams.
// Define FT245SFF_DEV_LOOPBACK_EN to route client writes back to client reads.
module ft245sff_dev
    import ft245_pkg::*;
#(
    parameter int DEPTH_LOG2     = FT245_DEPTH_LOG2,
    parameter int STARTUP_CYCLES = FT245_STARTUP_CYCLES
) (
    input  logic                    Clk,
    input  logic                    ARst,
    output logic                    RXFn,
    input  logic                    OEn,
    input  logic                    RDn,
    output logic [FT245_DATA_W-1:0] ADBUS_Rd,
    output logic                    TXEn,
    input  logic                    WRn,
    input  logic [FT245_DATA_W-1:0] ADBUS_Wr,
    input  logic                    SIWU,
    input  logic [FT245_DATA_W-1:0] In_Data,
    input  logic                    In_Valid,
    output logic                    In_Rdy,
    output logic [FT245_DATA_W-1:0] Out_Data,
    output logic                    Out_Valid,
    input  logic                    Out_Rdy,
    output logic [DEPTH_LOG2:0]     RxLevel,
    output logic [DEPTH_LOG2:0]     TxLevel,
    output logic                    Err_TxOvf
);
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(2 ** DEPTH_LOG2);
    localparam int CNT_W = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STARTUP_CYCLES);

    logic [CNT_W-1:0]        start_cnt;
    logic                    started;
    logic                    rd_beat, wr_beat;
    logic                    rx_push, rx_pop, tx_push, tx_pop;
    logic [FT245_DATA_W-1:0] rx_din, rx_head, tx_head;
    logic [DEPTH_LOG2:0]     rx_next, tx_next;
    logic                    in_rdy_next;

    assign started = (start_cnt == CNT_DONE);
    assign rd_beat = ~RXFn & ~OEn & ~RDn;
    assign wr_beat = ~TXEn & ~WRn;
    assign rx_pop  = rd_beat;
    assign tx_push = wr_beat;

`ifdef FT245SFF_DEV_LOOPBACK_EN
    logic lb_move;
    logic unused_host;
    assign lb_move     = (TxLevel != '0) && (RxLevel != FULL);
    assign rx_push     = lb_move;
    assign rx_din      = tx_head;
    assign tx_pop      = lb_move;
    assign Out_Valid   = 1'b0;
    assign Out_Data    = '0;
    assign in_rdy_next = 1'b0;
    assign unused_host = ^{SIWU, In_Data, In_Valid, Out_Rdy};
`else
    logic unused_siwu;
    assign rx_push     = In_Valid & In_Rdy;
    assign rx_din      = In_Data;
    assign tx_pop      = Out_Valid & Out_Rdy;
    assign Out_Valid   = (TxLevel != '0);
    assign Out_Data    = tx_head;
    assign in_rdy_next = (rx_next != FULL);
    assign unused_siwu = SIWU;
`endif

    ft245_dev_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk(Clk), .rst(ARst), .push(rx_push), .pop(rx_pop), .din(rx_din),
        .head(rx_head), .level(RxLevel), .level_next(rx_next)
    );

    ft245_dev_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk(Clk), .rst(ARst), .push(tx_push), .pop(tx_pop), .din(ADBUS_Wr),
        .head(tx_head), .level(TxLevel), .level_next(tx_next)
    );

    assign ADBUS_Rd = OEn ? '0 : rx_head;

    // Flags are registered from next-cycle occupancy so they are exact on every edge.
    always_ff @(posedge Clk or posedge ARst) begin
        if (ARst) begin
            start_cnt <= '0;
            RXFn      <= 1'b1;
            TXEn      <= 1'b1;
            In_Rdy    <= 1'b0;
            Err_TxOvf <= 1'b0;
        end else begin
            if (!started) start_cnt <= start_cnt + CNT_W'(1);
            RXFn   <= ~(started & (rx_next != '0));
            TXEn   <= ~(started & (tx_next != FULL));
            In_Rdy <= in_rdy_next;
            if (~WRn & TXEn) Err_TxOvf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ft245sff_dev.sv
// Self-checking bench for ft245sff_dev: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_ft245sff_dev;
    localparam int DL    = 2;
    localparam int SC    = 4;
    localparam int DEPTH = 2 ** DL;

    logic        Clk = 1'b0;
    logic        ARst = 1'b0;
    logic        RXFn, TXEn, In_Rdy, Out_Valid, Err_TxOvf;
    logic        OEn = 1'b1, RDn = 1'b1, WRn = 1'b1, SIWU = 1'b0;
    logic        In_Valid = 1'b0, Out_Rdy = 1'b0;
    logic [7:0]  ADBUS_Rd, ADBUS_Wr = 8'h00, In_Data = 8'h00, Out_Data;
    logic [DL:0] RxLevel, TxLevel;

    int passed = 0;
    int total  = 0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit         m_rxfn, m_txen, m_inrdy, m_err;
    int         m_cnt;

    ft245sff_dev #(.DEPTH_LOG2(DL), .STARTUP_CYCLES(SC)) dut (
        .Clk(Clk), .ARst(ARst), .RXFn(RXFn), .OEn(OEn), .RDn(RDn),
        .ADBUS_Rd(ADBUS_Rd), .TXEn(TXEn), .WRn(WRn), .ADBUS_Wr(ADBUS_Wr),
        .SIWU(SIWU), .In_Data(In_Data), .In_Valid(In_Valid), .In_Rdy(In_Rdy),
        .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Rdy(Out_Rdy),
        .RxLevel(RxLevel), .TxLevel(TxLevel), .Err_TxOvf(Err_TxOvf)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle();
        OEn = 1'b1; RDn = 1'b1; WRn = 1'b1; In_Valid = 1'b0; Out_Rdy = 1'b0; SIWU = 1'b0;
    endtask

    // Advance one clock edge; DUT and reference model see the same inputs.
    task automatic tick();
        bit rd, wr, hp, hpop, ovf, st;
        logic [7:0] hd, wd;
        rd   = !m_rxfn && !OEn && !RDn;
        wr   = !m_txen && !WRn;
        ovf  = m_txen && !WRn;
        hp   = In_Valid && m_inrdy;
        hpop = (txq.size() != 0) && Out_Rdy;
        hd   = In_Data;
        wd   = ADBUS_Wr;
        st   = (m_cnt >= SC);
        @(posedge Clk);
        #1;
        if (rd)   void'(rxq.pop_front());
        if (hp)   rxq.push_back(hd);
        if (hpop) void'(txq.pop_front());
        if (wr)   txq.push_back(wd);
        if (ovf)  m_err = 1'b1;
        m_rxfn  = !(st && rxq.size() != 0);
        m_txen  = !(st && txq.size() != DEPTH);
        m_inrdy = (rxq.size() != DEPTH);
        if (m_cnt < SC) m_cnt++;
    endtask

    task automatic do_reset();
        idle();
        @(negedge Clk);
        ARst = 1'b1;
        @(posedge Clk);
        #1;
        ARst = 1'b0;
        rxq.delete(); txq.delete();
        m_rxfn = 1'b1; m_txen = 1'b1; m_inrdy = 1'b0; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic wait_start();
        repeat (SC + 1) tick();
    endtask

    task automatic test_reset();
        idle();
        @(negedge Clk);
        ARst = 1'b1;
        OEn  = 1'b0;
        #2;
        total++; if (RXFn !== 1'b1) $display("FAIL reset_rxfn got %b want 1", RXFn); else passed++;
        total++; if (TXEn !== 1'b1) $display("FAIL reset_txen got %b want 1", TXEn); else passed++;
        total++; if (ADBUS_Rd !== 8'h00) $display("FAIL reset_adbus got %h want 00", ADBUS_Rd); else passed++;
        total++; if (In_Rdy !== 1'b0) $display("FAIL reset_inrdy got %b want 0", In_Rdy); else passed++;
        total++; if (Out_Valid !== 1'b0) $display("FAIL reset_outvalid got %b want 0", Out_Valid); else passed++;
        total++; if (Out_Data !== 8'h00) $display("FAIL reset_outdata got %h want 00", Out_Data); else passed++;
        total++; if (RxLevel !== '0) $display("FAIL reset_rxlevel got %0d want 0", RxLevel); else passed++;
        total++; if (TxLevel !== '0) $display("FAIL reset_txlevel got %0d want 0", TxLevel); else passed++;
        total++; if (Err_TxOvf !== 1'b0) $display("FAIL reset_err got %b want 0", Err_TxOvf); else passed++;
        do_reset();
    endtask

    task automatic test_startup();
        do_reset();
        tick();
        In_Valid = 1'b1; In_Data = 8'hA5;
        tick();
        In_Valid = 1'b0;
        for (int e = 2; e <= SC; e++) begin
            total++; if (RXFn !== 1'b1) $display("FAIL startup_rxfn_hi cycle %0d got %b want 1", e, RXFn); else passed++;
            total++; if (TXEn !== 1'b1) $display("FAIL startup_txen_hi cycle %0d got %b want 1", e, TXEn); else passed++;
            if (e < SC) tick();
        end
        tick();
        total++; if (RXFn !== 1'b0) $display("FAIL startup_rxfn_lo got %b want 0", RXFn); else passed++;
        total++; if (TXEn !== 1'b0) $display("FAIL startup_txen_lo got %b want 0", TXEn); else passed++;
        OEn = 1'b0;
        #1;
        total++; if (ADBUS_Rd !== 8'hA5) $display("FAIL startup_head got %h want a5", ADBUS_Rd); else passed++;
        OEn = 1'b1;
    endtask

    task automatic test_read_burst();
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        do_reset();
        wait_start();
        for (int i = 0; i < 3; i++) begin
            In_Valid = 1'b1; In_Data = bytes[i];
            tick();
        end
        In_Valid = 1'b0;
        total++; if (RXFn !== 1'b0) $display("FAIL burst_rxfn_ready got %b want 0", RXFn); else passed++;
        OEn = 1'b0; RDn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ADBUS_Rd !== bytes[i]) $display("FAIL burst_byte%0d got %h want %h", i, ADBUS_Rd, bytes[i]); else passed++;
            tick();
        end
        RDn = 1'b1;
        total++; if (RXFn !== 1'b1) $display("FAIL burst_rxfn_empty got %b want 1", RXFn); else passed++;
        total++; if (RxLevel !== '0) $display("FAIL burst_rxlevel got %0d want 0", RxLevel); else passed++;
        OEn = 1'b1;
    endtask

    task automatic test_tx_overflow();
        do_reset();
        wait_start();
        Out_Rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            WRn = 1'b0; ADBUS_Wr = 8'(i);
            tick();
        end
        total++; if (TXEn !== 1'b1) $display("FAIL ovf_txen_full got %b want 1", TXEn); else passed++;
        total++; if (Err_TxOvf !== 1'b0) $display("FAIL ovf_err_early got %b want 0", Err_TxOvf); else passed++;
        ADBUS_Wr = 8'h05;
        tick();
        WRn = 1'b1;
        total++; if (Err_TxOvf !== 1'b1) $display("FAIL ovf_err got %b want 1", Err_TxOvf); else passed++;
        total++; if (TxLevel !== 3'(4)) $display("FAIL ovf_txlevel got %0d want 4", TxLevel); else passed++;
        Out_Rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            total++; if (Out_Valid !== 1'b1 || Out_Data !== 8'(i))
                $display("FAIL ovf_drain%0d got v=%b d=%h want v=1 d=%h", i, Out_Valid, Out_Data, 8'(i));
            else passed++;
            tick();
        end
        Out_Rdy = 1'b0;
        total++; if (Out_Valid !== 1'b0) $display("FAIL ovf_drained got %b want 0", Out_Valid); else passed++;
        total++; if (Err_TxOvf !== 1'b1) $display("FAIL ovf_sticky got %b want 1", Err_TxOvf); else passed++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        wait_start();
        In_Valid = 1'b1; In_Data = 8'h44;
        tick();
        In_Data = 8'h55; OEn = 1'b0; RDn = 1'b0;
        tick();
        In_Valid = 1'b0; RDn = 1'b1;
        total++; if (RxLevel !== 3'(1)) $display("FAIL simul_level got %0d want 1", RxLevel); else passed++;
        total++; if (ADBUS_Rd !== 8'h55) $display("FAIL simul_head got %h want 55", ADBUS_Rd); else passed++;
        OEn = 1'b1;
    endtask

    task automatic test_oen_high();
        OEn = 1'b1; RDn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (ADBUS_Rd !== 8'h00) $display("FAIL oenhi_bus%0d got %h want 00", i, ADBUS_Rd); else passed++;
            total++; if (RxLevel !== 3'(1)) $display("FAIL oenhi_level%0d got %0d want 1", i, RxLevel); else passed++;
        end
        RDn = 1'b1;
        OEn = 1'b0;
        #1;
        total++; if (ADBUS_Rd !== 8'h55) $display("FAIL oenhi_kept got %h want 55", ADBUS_Rd); else passed++;
        OEn = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] exp_rd, exp_out;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            OEn      = ($urandom_range(0, 3) == 0);
            RDn      = ($urandom_range(0, 2) == 0);
            WRn      = ($urandom_range(0, 2) == 0);
            ADBUS_Wr = 8'($urandom);
            In_Valid = ($urandom_range(0, 1) == 1);
            In_Data  = 8'($urandom);
            Out_Rdy  = ($urandom_range(0, 2) != 0);
            tick();
            exp_rd  = (!OEn && rxq.size() != 0) ? rxq[0] : 8'h00;
            exp_out = (txq.size() != 0) ? txq[0] : 8'h00;
            total++;
            if (RXFn !== m_rxfn || TXEn !== m_txen || In_Rdy !== m_inrdy || Err_TxOvf !== m_err)
                $display("FAIL rand_flags cyc %0d got rxf=%b txe=%b rdy=%b err=%b want %b %b %b %b",
                         n, RXFn, TXEn, In_Rdy, Err_TxOvf, m_rxfn, m_txen, m_inrdy, m_err);
            else passed++;
            total++;
            if (RxLevel !== (DL+1)'(rxq.size()) || TxLevel !== (DL+1)'(txq.size()))
                $display("FAIL rand_levels cyc %0d got rx=%0d tx=%0d want %0d %0d",
                         n, RxLevel, TxLevel, rxq.size(), txq.size());
            else passed++;
            total++;
            if (ADBUS_Rd !== exp_rd || Out_Data !== exp_out || Out_Valid !== (txq.size() != 0))
                $display("FAIL rand_data cyc %0d got rd=%h out=%h v=%b want %h %h %b",
                         n, ADBUS_Rd, Out_Data, Out_Valid, exp_rd, exp_out, txq.size() != 0);
            else passed++;
        end
        idle();
    endtask

    task automatic test_loopback();
        bit seen;
        do_reset();
        wait_start();
        WRn = 1'b0; ADBUS_Wr = 8'hC3;
        tick();
        WRn = 1'b1; OEn = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            if (RXFn === 1'b0) seen = 1'b1;
        end
        total++; if (!seen) $display("FAIL loop_rxfn got %b want 0 within 2 cycles", RXFn); else passed++;
        total++; if (ADBUS_Rd !== 8'hC3) $display("FAIL loop_byte got %h want c3", ADBUS_Rd); else passed++;
        total++; if (Out_Valid !== 1'b0) $display("FAIL loop_outvalid got %b want 0", Out_Valid); else passed++;
        total++; if (In_Rdy !== 1'b0) $display("FAIL loop_inrdy got %b want 0", In_Rdy); else passed++;
        OEn = 1'b1;
    endtask

    initial begin
        test_reset();
`ifdef FT245SFF_DEV_LOOPBACK_EN
        test_loopback();
`else
        test_startup();
        test_read_burst();
        test_tx_overflow();
        test_simultaneous();
        test_oen_high();
        test_random();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
